// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// I-type/load (rt) and R-type (rd) writeback paths, with a registered write stage.
module regfile_wport_arbiter #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int CNT_W       = 8,
   parameter int SUPPRESS_R0 = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] data_a,
   output logic              gnt_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_b,
   output logic              gnt_b,
   output logic              rf_sel,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              busy,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   prio_t             ptr;
   prio_t             ptr_next;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic              win_is_r0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PRIO_A;
      end else begin
         ptr <= ptr_next;
      end
   end

   // Grants are gated by rst_n so they fall the instant reset asserts.
   always_comb begin
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      ptr_next = ptr;
      if (rst_n) begin
         if (req_a && (!req_b || ptr == PRIO_A)) begin
            gnt_a = 1'b1;
         end else if (req_b) begin
            gnt_b = 1'b1;
         end
      end
      if (gnt_a) begin
         ptr_next = PRIO_B;
      end else if (gnt_b) begin
         ptr_next = PRIO_A;
      end
   end

   assign busy      = req_a & req_b;
   assign win_addr  = gnt_b ? addr_b : addr_a;
   assign win_data  = gnt_b ? data_b : data_a;
   assign win_is_r0 = (SUPPRESS_R0 != 0) && (win_addr == '0);

   // Idle cycles only drop the enable; the last address/data/select are held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_sel   <= 1'b0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (gnt_a || gnt_b) begin
         rf_sel   <= gnt_b;
         rf_we    <= !win_is_r0;
         rf_waddr <= win_addr;
         rf_wdata <= win_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (busy && conflict_cnt != CNT_MAX) begin
         conflict_cnt <= conflict_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed table, hand sequences
// for saturation and mid-cycle reset, and randomized traffic against a model.
module tb_regfile_wport_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req_a, req_b;
   logic [4:0]  addr_a, addr_b;
   logic [31:0] data_a, data_b;
   logic        gnt_a, gnt_b, rf_sel, rf_we, busy;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [7:0]  conflict_cnt;

   logic        s_gnt_a, s_gnt_b, s_rf_sel, s_rf_we, s_busy;
   logic [4:0]  s_rf_waddr;
   logic [31:0] s_rf_wdata;
   logic [1:0]  s_conflict_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   bit          m_fav_b;
   bit          m_we, m_sel;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int          m_cnt, m_cnt2;
   bit          last_ga, last_gb;

   typedef struct {
      logic        req_a;
      logic [4:0]  addr_a;
      logic [31:0] data_a;
      logic        req_b;
      logic [4:0]  addr_b;
      logic [31:0] data_b;
      logic        gnt_a, gnt_b, we, sel;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs[9];

   regfile_wport_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
      .rf_sel(rf_sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .conflict_cnt(conflict_cnt)
   );

   regfile_wport_arbiter #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(s_gnt_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(s_gnt_b),
      .rf_sel(s_rf_sel), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
      .busy(s_busy), .conflict_cnt(s_conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic ra, input logic [4:0] aa, input logic [31:0] da,
                                input logic rb, input logic [4:0] ab, input logic [31:0] db);
      req_a  = ra; addr_a = aa; data_a = da;
      req_b  = rb; addr_b = ab; data_b = db;
   endtask

   task automatic modelReset();
      m_fav_b = 0; m_we = 0; m_sel = 0; m_waddr = '0; m_wdata = '0;
      m_cnt = 0; m_cnt2 = 0; last_ga = 0; last_gb = 0;
   endtask

   // One clock cycle: check combinational outputs, step model at the edge,
   // then check registered outputs; returns at the following negedge.
   task automatic doCycle();
      bit e_ga, e_gb;
      #1;
      e_ga = req_a && (!req_b || !m_fav_b);
      e_gb = req_b && !e_ga;
      checkOutput("gnt_a", {31'b0, gnt_a}, {31'b0, e_ga});
      checkOutput("gnt_b", {31'b0, gnt_b}, {31'b0, e_gb});
      checkOutput("busy", {31'b0, busy}, {31'b0, req_a & req_b});
      @(posedge clk);
      if (e_ga || e_gb) begin
         m_sel   = e_gb;
         m_waddr = e_gb ? addr_b : addr_a;
         m_wdata = e_gb ? data_b : data_a;
         m_we    = (m_waddr != 0);
         m_fav_b = e_ga;
      end else begin
         m_we = 0;
      end
      if (req_a && req_b) begin
         if (m_cnt < 255) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      last_ga = e_ga;
      last_gb = e_gb;
      #1;
      checkOutput("rf_we", {31'b0, rf_we}, {31'b0, m_we});
      checkOutput("rf_sel", {31'b0, rf_sel}, {31'b0, m_sel});
      checkOutput("rf_waddr", {27'b0, rf_waddr}, {27'b0, m_waddr});
      checkOutput("rf_wdata", rf_wdata, m_wdata);
      checkOutput("conflict_cnt", {24'b0, conflict_cnt}, m_cnt);
      checkOutput("conflict_cnt_sat", {30'b0, s_conflict_cnt}, m_cnt2);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] exp_sel_seq;
      exp_sel_seq = 2'b10;

      vecs[0] = '{1, 9,  32'hDEADBEEF, 0, 0,  32'h0,        1, 0, 1, 0, 9,  32'hDEADBEEF, 0};
      vecs[1] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 9,  32'hDEADBEEF, 0};
      vecs[2] = '{1, 3,  32'hA0000002, 1, 7,  32'hB0000002, 0, 1, 1, 1, 7,  32'hB0000002, 1};
      vecs[3] = '{1, 3,  32'hA0000003, 1, 7,  32'hB0000003, 1, 0, 1, 0, 3,  32'hA0000003, 2};
      vecs[4] = '{0, 0,  32'h0,        1, 0,  32'h00001234, 0, 1, 0, 1, 0,  32'h00001234, 2};
      vecs[5] = '{1, 0,  32'h00000055, 0, 0,  32'h0,        1, 0, 0, 0, 0,  32'h00000055, 2};
      vecs[6] = '{1, 12, 32'hA0000006, 1, 12, 32'hB0000006, 0, 1, 1, 1, 12, 32'hB0000006, 3};
      vecs[7] = '{1, 12, 32'hA0000007, 1, 12, 32'hB0000007, 1, 0, 1, 0, 12, 32'hA0000007, 4};
      vecs[8] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 12, 32'hA0000007, 4};

      // Reset, then five idle cycles
      doReset();
      checkOutput("reset_rf_we", {31'b0, rf_we}, 32'd0);
      checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
      repeat (5) doCycle();

      // Both held after reset: strict alternation A,B,A,B then saturation
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 3, 32'h11110000 + i, 1, 7, 32'h22220000 + i);
         doCycle();
         if (i < 4) checkOutput("alt_sel", {31'b0, rf_sel}, {31'b0, exp_sel_seq[i % 2]});
         if (i == 3) checkOutput("alt_cnt4", {24'b0, conflict_cnt}, 32'd4);
         if (i >= 3) checkOutput("sat_cnt3", {30'b0, s_conflict_cnt}, 32'd3);
      end
      checkOutput("alt_cnt6", {24'b0, conflict_cnt}, 32'd6);

      // Directed table
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].req_a, vecs[i].addr_a, vecs[i].data_a,
                       vecs[i].req_b, vecs[i].addr_b, vecs[i].data_b);
         #1;
         checkOutput("tbl_gnt_a", {31'b0, gnt_a}, {31'b0, vecs[i].gnt_a});
         checkOutput("tbl_gnt_b", {31'b0, gnt_b}, {31'b0, vecs[i].gnt_b});
         doCycle();
         checkOutput("tbl_we", {31'b0, rf_we}, {31'b0, vecs[i].we});
         checkOutput("tbl_sel", {31'b0, rf_sel}, {31'b0, vecs[i].sel});
         checkOutput("tbl_waddr", {27'b0, rf_waddr}, {27'b0, vecs[i].waddr});
         checkOutput("tbl_wdata", rf_wdata, vecs[i].wdata);
         checkOutput("tbl_cnt", {24'b0, conflict_cnt}, {24'b0, vecs[i].cnt});
      end

      // Reset asserted mid-cycle while A holds a grant
      applyStimulus(1, 5, 32'hCAFE0001, 0, 0, 0);
      #1;
      checkOutput("mid_gnt_before", {31'b0, gnt_a}, 32'd1);
      #1;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("mid_gnt_a_drop", {31'b0, gnt_a}, 32'd0);
      checkOutput("mid_rf_we", {31'b0, rf_we}, 32'd0);
      checkOutput("mid_rf_wdata", rf_wdata, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("mid_no_write", {31'b0, rf_we}, 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      repeat (2) doCycle();

      // Randomized traffic; requesters hold until granted
      for (int i = 0; i < 400; i++) begin
         logic        ra, rb;
         logic [4:0]  aa, ab;
         logic [31:0] da, db;
         if (req_a && !last_ga) begin
            ra = 1; aa = addr_a; da = data_a;
         end else begin
            ra = ($urandom_range(0, 2) != 0);
            aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            da = $urandom;
         end
         if (req_b && !last_gb) begin
            rb = 1; ab = addr_b; db = data_b;
         end else begin
            rb = ($urandom_range(0, 2) != 0);
            ab = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            db = $urandom;
         end
         applyStimulus(ra, aa, da, rb, ab, db);
         doCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
